// File: rtl/gpio_sw_led.sv
// Memory-mapped switch/LED peripheral: synchronised, debounced switches with
// rise/fall edge capture and interrupt, plus an LED register with set/clear/toggle.
module gpio_sw_led #(
   parameter int                   SW_WIDTH        = 8,
   parameter int                   LED_WIDTH       = 8,
   parameter int                   DEBOUNCE_CYCLES = 16,
   parameter logic [LED_WIDTH-1:0] LED_RESET       = '0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [SW_WIDTH-1:0]  SW,
   output logic [LED_WIDTH-1:0] LED,
   input  logic                 SEL,
   input  logic                 WE,
   input  logic [2:0]           ADDR,
   input  logic [31:0]          WDATA,
   output logic [31:0]          RDATA,
   output logic                 RVALID,
   output logic                 IRQ
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SW_WIDTH-1:0]         meta;
   logic [SW_WIDTH-1:0]         sync;
   logic [SW_WIDTH-1:0]         db;
   logic [SW_WIDTH-1:0]         db_nxt;
   logic [SW_WIDTH-1:0][CW-1:0] cnt;
   logic [SW_WIDTH-1:0][CW-1:0] cnt_nxt;
   logic [SW_WIDTH-1:0]         rise_pend;
   logic [SW_WIDTH-1:0]         fall_pend;
   logic [SW_WIDTH-1:0]         rise_en;
   logic [SW_WIDTH-1:0]         fall_en;
   logic [SW_WIDTH-1:0]         rise_set;
   logic [SW_WIDTH-1:0]         fall_set;
   logic [SW_WIDTH-1:0]         clr_rise;
   logic [SW_WIDTH-1:0]         clr_fall;
   logic                        wr;
   logic                        rd;
   logic [31:0]                 rd_word;
   logic                        unused_wdata;

   assign wr           = SEL & WE;
   assign rd           = SEL & ~WE;
   assign unused_wdata = ^WDATA;

   // Per-bit debounce: any mismatch cycle counts, a return to db restarts from zero.
   always_comb begin
      db_nxt  = db;
      cnt_nxt = '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
         if (sync[i] == db[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CNT_LAST) begin
            db_nxt[i]  = sync[i];
            cnt_nxt[i] = '0;
         end else begin
            cnt_nxt[i] = cnt[i] + CW'(1);
         end
      end
   end

   assign rise_set = db_nxt & ~db;
   assign fall_set = db & ~db_nxt;

   // W1C strobes for the EDGE register.
   always_comb begin
      clr_rise = '0;
      clr_fall = '0;
      if (wr && (ADDR == 3'd5)) begin
         clr_rise = WDATA[SW_WIDTH-1:0];
         clr_fall = WDATA[16 +: SW_WIDTH];
      end else begin
         clr_rise = '0;
         clr_fall = '0;
      end
   end

   // Read mux over the pre-edge register contents; unused bits and WO/reserved read 0.
   always_comb begin
      rd_word = 32'h0000_0000;
      case (ADDR)
         3'd0: rd_word[SW_WIDTH-1:0] = db;
         3'd1: rd_word[LED_WIDTH-1:0] = LED;
         3'd5: begin
            rd_word[SW_WIDTH-1:0]   = rise_pend;
            rd_word[16 +: SW_WIDTH] = fall_pend;
         end
         3'd6: begin
            rd_word[SW_WIDTH-1:0]   = rise_en;
            rd_word[16 +: SW_WIDTH] = fall_en;
         end
         default: rd_word = 32'h0000_0000;
      endcase
   end

   // Switch path, edge capture, LED/enable writes and the registered read port.
   always_ff @(posedge CLK) begin
      if (RST) begin
         meta      <= '0;
         sync      <= '0;
         db        <= '0;
         cnt       <= '0;
         rise_pend <= '0;
         fall_pend <= '0;
         rise_en   <= '0;
         fall_en   <= '0;
         LED       <= LED_RESET;
         RDATA     <= 32'h0000_0000;
         RVALID    <= 1'b0;
      end else begin
         meta      <= SW;
         sync      <= meta;
         db        <= db_nxt;
         cnt       <= cnt_nxt;
         // A new edge beats a simultaneous clear so no event is lost.
         rise_pend <= (rise_pend & ~clr_rise) | rise_set;
         fall_pend <= (fall_pend & ~clr_fall) | fall_set;
         if (wr) begin
            case (ADDR)
               3'd1: LED <= WDATA[LED_WIDTH-1:0];
               3'd2: LED <= LED | WDATA[LED_WIDTH-1:0];
               3'd3: LED <= LED & ~WDATA[LED_WIDTH-1:0];
               3'd4: LED <= LED ^ WDATA[LED_WIDTH-1:0];
               3'd6: begin
                  rise_en <= WDATA[SW_WIDTH-1:0];
                  fall_en <= WDATA[16 +: SW_WIDTH];
               end
               default: ;
            endcase
         end
         RVALID <= rd;
         RDATA  <= rd ? rd_word : 32'h0000_0000;
      end
   end

   assign IRQ = (|(rise_pend & rise_en)) | (|(fall_pend & fall_en));

endmodule
